vec_stim_check: RTL and testbench

- Self-contained stimulus sequencer and response checker for CI regression of single-output combinational or pipelined primitives (nor/and/xor style DUTs).
- Sits directly around the DUT: holds the DUT in reset, drives a parameterised input-vector table upstream of it, and consumes its output downstream.
- Compares each output against the expected value after a fixed DUT latency, then reports pass/fail, first failing index and error count.

---
 rtl/vec_check_pkg.sv | 11 +
 rtl/vec_delay_line.sv | 52 +++++
 rtl/vec_stim_check.sv | 144 ++++++++++++++
 tb/tb_vec_stim_check.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_check_pkg.sv
// Shared state encoding and width helper for the vector stimulus checker.
package vec_check_pkg;

   typedef enum logic [2:0] {S_IDLE, S_HOLD, S_DRIVE, S_DRAIN, S_DONE} state_e;

   // Bits needed to index n items, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vec_delay_line.sv
// Delays {valid, idx, expect} by LATENCY cycles so the expected value lines up
// with the DUT response; depth 0 is a straight wire.
module vec_delay_line #(
   parameter int LATENCY = 1,
   parameter int IDX_W   = 2,
   parameter int DW      = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             vld_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [DW-1:0]    exp_i,
   output logic             vld_o,
   output logic [IDX_W-1:0] idx_o,
   output logic [DW-1:0]    exp_o
);

   if (LATENCY == 0) begin : g_pass
      assign vld_o = vld_i;
      assign idx_o = idx_i;
      assign exp_o = exp_i;
   end else begin : g_pipe
      logic [LATENCY-1:0]            vld_q;
      logic [LATENCY-1:0][IDX_W-1:0] idx_q;
      logic [LATENCY-1:0][DW-1:0]    exp_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            vld_q <= '0;
            idx_q <= '0;
            exp_q <= '0;
         end else if (flush_i) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= vld_i;
            idx_q[0] <= idx_i;
            exp_q[0] <= exp_i;
            for (int i = 1; i < LATENCY; i++) begin
               vld_q[i] <= vld_q[i-1];
               idx_q[i] <= idx_q[i-1];
               exp_q[i] <= exp_q[i-1];
            end
         end
      end

      assign vld_o = vld_q[LATENCY-1];
      assign idx_o = idx_q[LATENCY-1];
      assign exp_o = exp_q[LATENCY-1];
   end

endmodule

// File: rtl/vec_stim_check.sv
// Stimulus sequencer and response checker: resets the DUT, walks the vector
// table, compares delayed expectations against resp and reports the result.
module vec_stim_check
   import vec_check_pkg::*;
#(
   parameter int WIDTH_IN     = 2,
   parameter int WIDTH_OUT    = 1,
   parameter int NUM_VEC      = 4,
   parameter int LATENCY      = 1,
   parameter int HOLD_CYCLES  = 16,
   parameter int STOP_ON_FAIL = 1,
   parameter logic [NUM_VEC*WIDTH_IN-1:0]  STIM   = '0,
   parameter logic [NUM_VEC*WIDTH_OUT-1:0] EXPECT = '0,
   localparam int IDX_W = width_of(NUM_VEC),
   localparam int CNT_W = width_of(NUM_VEC + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   output logic                 dut_rst,
   output logic [WIDTH_IN-1:0]  stim,
   input  logic [WIDTH_OUT-1:0] resp,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [IDX_W-1:0]     fail_idx,
   output logic [CNT_W-1:0]     err_count
);

   localparam int HC_W = width_of(HOLD_CYCLES + 1);
   localparam int DC_W = width_of(LATENCY + 1);

   state_e               state_q;
   logic [IDX_W-1:0]     idx_q, fail_q;
   logic [CNT_W-1:0]     err_q, err_d;
   logic [HC_W-1:0]      hold_q;
   logic [DC_W-1:0]      drain_q;
   logic [WIDTH_IN-1:0]  stim_q;
   logic                 dut_rst_q, busy_q, done_q, pass_q;
   logic                 dl_vld;
   logic [IDX_W-1:0]     dl_idx;
   logic [WIDTH_OUT-1:0] dl_exp, exp_cur;
   logic                 mis, start_ok, last_vec, hold_end, drain_end, to_done, flush;

   function automatic logic [WIDTH_IN-1:0] vec_at(input logic [IDX_W-1:0] i);
      return STIM[int'(i)*WIDTH_IN +: WIDTH_IN];
   endfunction

   always_comb begin
      exp_cur   = EXPECT[int'(idx_q)*WIDTH_OUT +: WIDTH_OUT];
      start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
      // Case-inequality so an X/Z response is reported rather than masked.
      mis       = dl_vld && (resp !== dl_exp) && (state_q == S_DRIVE || state_q == S_DRAIN);
      err_d     = (mis && err_q != '1) ? err_q + 1'b1 : err_q;
      last_vec  = idx_q == IDX_W'(NUM_VEC - 1);
      hold_end  = (HOLD_CYCLES <= 1) || (hold_q == HC_W'(HOLD_CYCLES - 1));
      drain_end = drain_q == DC_W'(LATENCY - 1);
      to_done   = (state_q == S_DRIVE && ((mis && STOP_ON_FAIL != 0) || (last_vec && LATENCY == 0))) ||
                  (state_q == S_DRAIN && ((mis && STOP_ON_FAIL != 0) || drain_end));
      flush     = start_ok || to_done;
   end

   vec_delay_line #(.LATENCY(LATENCY), .IDX_W(IDX_W), .DW(WIDTH_OUT)) u_dly (
      .clk_i  (clock),
      .rst_ni (reset),
      .flush_i(flush),
      .vld_i  (state_q == S_DRIVE),
      .idx_i  (idx_q),
      .exp_i  (exp_cur),
      .vld_o  (dl_vld),
      .idx_o  (dl_idx),
      .exp_o  (dl_exp)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         hold_q    <= '0;
         drain_q   <= '0;
         stim_q    <= '0;
         dut_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= '0;
         err_q     <= '0;
      end else begin
         err_q <= err_d;
         if (mis && err_q == '0) fail_q <= dl_idx;
         case (state_q)
            S_IDLE, S_DONE: if (start_ok) begin
               state_q   <= S_HOLD;
               hold_q    <= '0;
               err_q     <= '0;
               fail_q    <= '0;
               done_q    <= 1'b0;
               pass_q    <= 1'b0;
               busy_q    <= 1'b1;
               dut_rst_q <= 1'b1;
               stim_q    <= '0;
            end
            S_HOLD: if (hold_end) begin
               state_q   <= S_DRIVE;
               idx_q     <= '0;
               stim_q    <= vec_at('0);
               dut_rst_q <= 1'b0;
            end else begin
               hold_q <= hold_q + 1'b1;
            end
            S_DRIVE: if (to_done) begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               pass_q  <= (err_d == '0);
            end else if (last_vec) begin
               state_q <= S_DRAIN;
               drain_q <= '0;
            end else begin
               idx_q  <= idx_q + 1'b1;
               stim_q <= vec_at(idx_q + 1'b1);
            end
            S_DRAIN: if (to_done) begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               pass_q  <= (err_d == '0);
            end else begin
               drain_q <= drain_q + 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dut_rst   = dut_rst_q;
   assign stim      = stim_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_idx  = fail_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_vec_stim_check.sv
// Bench for vec_stim_check: NOR table against correct, stuck-at-1 and
// twice-registered DUTs, plus start/reset corner cases.
module tb_vec_stim_check;

   localparam logic [7:0] STIM_P = 8'b11_01_10_00;
   localparam logic [3:0] EXP_P  = 4'b0001;
   localparam int         HOLD   = 16;

   logic clock = 1'b0, reset = 1'b0, start = 1'b0, start_b = 1'b0, force0 = 1'b0;
   always #5 clock = ~clock;

   int tests = 0, fails = 0;

   logic       rst0, busy0, done0, pass0, resp0;
   logic [1:0] stim0, fail0;
   logic [2:0] err0;
   logic       rst1, busy1, done1, pass1, rst2, busy2, done2, pass2, rst3, busy3, done3, pass3;
   logic [1:0] stim1, fail1, stim2, fail2, stim3, fail3;
   logic [2:0] err1, err2, err3;
   logic       r2a, r2b, r3a, r3b;

   assign resp0 = force0 ? 1'b1 : ~(stim0[1] | stim0[0]);

   vec_stim_check #(.LATENCY(0), .STOP_ON_FAIL(1), .HOLD_CYCLES(HOLD), .STIM(STIM_P), .EXPECT(EXP_P)) u0 (
      .clock(clock), .reset(reset), .start(start), .dut_rst(rst0), .stim(stim0), .resp(resp0),
      .busy(busy0), .done(done0), .pass(pass0), .fail_idx(fail0), .err_count(err0));
   vec_stim_check #(.LATENCY(0), .STOP_ON_FAIL(0), .HOLD_CYCLES(HOLD), .STIM(STIM_P), .EXPECT(EXP_P)) u1 (
      .clock(clock), .reset(reset), .start(start_b), .dut_rst(rst1), .stim(stim1), .resp(1'b1),
      .busy(busy1), .done(done1), .pass(pass1), .fail_idx(fail1), .err_count(err1));
   vec_stim_check #(.LATENCY(2), .STOP_ON_FAIL(1), .HOLD_CYCLES(HOLD), .STIM(STIM_P), .EXPECT(EXP_P)) u2 (
      .clock(clock), .reset(reset), .start(start_b), .dut_rst(rst2), .stim(stim2), .resp(r2b),
      .busy(busy2), .done(done2), .pass(pass2), .fail_idx(fail2), .err_count(err2));
   vec_stim_check #(.LATENCY(0), .STOP_ON_FAIL(1), .HOLD_CYCLES(HOLD), .STIM(STIM_P), .EXPECT(EXP_P)) u3 (
      .clock(clock), .reset(reset), .start(start_b), .dut_rst(rst3), .stim(stim3), .resp(r3b),
      .busy(busy3), .done(done3), .pass(pass3), .fail_idx(fail3), .err_count(err3));

   // Correct NOR registered twice, synchronously reset by the checker.
   always @(posedge clock) begin
      if (rst2) begin r2a <= 1'b0; r2b <= 1'b0; end
      else begin r2a <= ~|stim2; r2b <= r2a; end
      if (rst3) begin r3a <= 1'b0; r3b <= 1'b0; end
      else begin r3a <= ~|stim3; r3b <= r3a; end
   end

   int bc1 = 0, bc2 = 0, bc3 = 0;
   always @(posedge clock) begin
      if (busy1) bc1 <= bc1 + 1;
      if (busy2) bc2 <= bc2 + 1;
      if (busy3) bc3 <= bc3 + 1;
   end

   logic watch = 1'b0, seen2 = 1'b0;
   always @(negedge clock) if (watch && stim0 == 2'b01) seen2 <= 1'b1;

   // Model of u0: a queue of per-cycle observations built when a run starts.
   typedef struct packed {logic busy; logic done; logic rst; logic [1:0] stim;} obs_t;
   logic [1:0] m_vec [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
   logic       m_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
   obs_t q[$];
   obs_t cur = {1'b0, 1'b0, 1'b1, 2'b00};
   obs_t fin;
   logic ran = 1'b0, m_pass = 1'b0;
   int   m_err = 0, m_fail = 0;

   function automatic obs_t mk(input logic b, input logic d, input logic r, input logic [1:0] s);
      return {b, d, r, s};
   endfunction

   task automatic build();
      int e = 0;
      int f = 0;
      logic [1:0] last = 2'b00;
      logic r;
      q.delete();
      repeat (HOLD) q.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00));
      for (int i = 0; i < 4; i++) begin
         q.push_back(mk(1'b1, 1'b0, 1'b0, m_vec[i]));
         last = m_vec[i];
         r = force0 ? 1'b1 : ~(m_vec[i][1] | m_vec[i][0]);
         if (r != m_exp[i]) begin
            if (e == 0) f = i;
            e++;
            break;
         end
      end
      fin = mk(1'b0, 1'b1, 1'b0, last);
      m_pass = (e == 0); m_err = e; m_fail = f; ran = 1'b1;
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         q.delete(); cur = mk(1'b0, 1'b0, 1'b1, 2'b00); ran = 1'b0;
      end else begin
         if (start && !cur.busy) build();
         if (q.size() > 0) cur = q.pop_front();
         else if (ran) cur = fin;
      end
   end

   always @(negedge clock) begin
      tests++;
      if ({busy0, done0, rst0, stim0} !== cur) begin
         fails++;
         $display("FAIL u0_obs busy/done/rst/stim got %b exp %b at %0t", {busy0, done0, rst0, stim0}, cur, $time);
      end
      if (cur.done || (!ran && !cur.busy)) begin
         tests++;
         if ({pass0, err0, fail0} !== {cur.done ? m_pass : 1'b0, cur.done ? 3'(m_err) : 3'd0,
                                       cur.done ? 2'(m_fail) : 2'd0}) begin
            fails++;
            $display("FAIL u0_result pass/err/fail got %b/%0d/%0d exp %b/%0d/%0d at %0t",
                     pass0, err0, fail0, m_pass, m_err, m_fail, $time);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_start();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
   endtask

   task automatic wait_done0(input string name);
      int k = 0;
      while (!done0 && k < 100) begin @(negedge clock); k++; end
      chk(name, 32'(done0), 32'd1);
   endtask

   initial begin
      int k = 0;
      cycles(2);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_dutrst", 32'(rst0), 32'd1);
      chk("rst_stim", 32'(stim0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      reset = 1'b1;

      // Stuck-at-1 no-stop, twice-registered with LATENCY=2, same DUT with LATENCY=0.
      @(negedge clock) start_b = 1'b1;
      @(negedge clock) start_b = 1'b0;
      while (!(done1 && done2 && done3) && k < 100) begin @(negedge clock); k++; end
      chk("grp_done_timeout", 32'(done1 & done2 & done3), 32'd1);
      chk("nostop_err", 32'(err1), 32'd3);
      chk("nostop_fidx", 32'(fail1), 32'd1);
      chk("nostop_pass", 32'(pass1), 32'd0);
      chk("nostop_busy_cycles", 32'(bc1), 32'd20);
      chk("lat2_pass", 32'(pass2), 32'd1);
      chk("lat2_err", 32'(err2), 32'd0);
      chk("lat2_busy_cycles", 32'(bc2), 32'd22);
      chk("lat0_on_delayed_pass", 32'(pass3), 32'd0);
      chk("lat0_on_delayed_err", 32'(err3), 32'd1);
      chk("lat0_on_delayed_fidx", 32'(fail3), 32'd0);
      chk("lat0_on_delayed_busy", 32'(bc3), 32'd17);

      // Correct NOR, with a start pulse during HOLD that must be ignored.
      force0 = 1'b0;
      pulse_start();
      cycles(5); start = 1'b1;
      cycles(1); start = 1'b0;
      cycles(13);
      chk("nor_done_early", 32'(done0), 32'd0);
      cycles(1);
      chk("nor_done_at_20", 32'(done0), 32'd1);
      chk("nor_pass", 32'(pass0), 32'd1);
      chk("nor_err", 32'(err0), 32'd0);
      chk("nor_fidx", 32'(fail0), 32'd0);

      // Stuck-at-1 with stop; start on the DONE-entry edge is ignored.
      force0 = 1'b1; watch = 1'b1;
      pulse_start();
      cycles(17); start = 1'b1;
      cycles(1);  start = 1'b0;
      watch = 1'b0;
      chk("stop_done", 32'(done0), 32'd1);
      chk("stop_err", 32'(err0), 32'd1);
      chk("stop_fidx", 32'(fail0), 32'd1);
      chk("stop_pass", 32'(pass0), 32'd0);
      chk("stop_no_vec2", 32'(seen2), 32'd0);
      cycles(1);
      chk("done_entry_start_ignored", 32'(done0), 32'd1);
      start = 1'b1;
      cycles(1); start = 1'b0;
      chk("restart_busy", 32'(busy0), 32'd1);
      chk("restart_done_clr", 32'(done0), 32'd0);
      chk("restart_err_clr", 32'(err0), 32'd0);
      chk("restart_fidx_clr", 32'(fail0), 32'd0);
      wait_done0("restart_done_timeout");

      // Async reset while vector 2 is on stim, then a clean rerun.
      force0 = 1'b0;
      pulse_start();
      cycles(18);
      chk("mid_stim_vec2", 32'(stim0), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_dutrst", 32'(rst0), 32'd1);
      chk("abort_stim", 32'(stim0), 32'd0);
      chk("abort_err", 32'(err0), 32'd0);
      @(negedge clock) reset = 1'b1;
      pulse_start();
      wait_done0("rerun_done_timeout");
      chk("rerun_pass", 32'(pass0), 32'd1);

      cycles(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
